// File: rtl/divider_seq_32b_pkg.sv
// Shared ALU definitions: operation select indices, divider defaults and
// the divider state encoding.
package divider_seq_32b_pkg;

  // One-hot select positions on the ALU result mux.
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_AND = 2;
  localparam int ALU_OR  = 3;
  localparam int ALU_DIV = 4;
  localparam int ALU_XOR = 5;
  localparam int ALU_MUL = 6;
  localparam int ALU_INC = 7;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CW    = 6;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = DIV_IDLE,
    S_RUN  = DIV_RUN,
    S_FIX  = DIV_FIX,
    S_DONE = DIV_DONE
  } div_state_e;

endpackage

// File: rtl/divider_step.sv
// One non-restoring division iteration: shift {A,Q} left, then add or
// subtract the divisor depending on the sign A had before the shift.
module divider_step
  import divider_seq_32b_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] m_ext;

  assign a_sh  = {a[WIDTH-1:0], q[WIDTH-1]};
  assign m_ext = {1'b0, m};

  // The shifted value may wrap, but the add/subtract brings A back into
  // [-M, M), so the sign must come from the pre-shift A.
  assign a_next = a[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
  assign q_next = {q[WIDTH-2:0], ~a_next[WIDTH]};

endmodule

// File: rtl/divider_seq_32b.sv
// Multi-cycle non-restoring divider: {remainder, quotient} of dividend/divisor.
// Define DIVIDER_SIGNED_EN for two's-complement operands (default: unsigned).
module divider_seq_32b
  import divider_seq_32b_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CW    = DIV_CW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc_a;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] m_reg;

  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   rem_fix;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

`ifdef DIVIDER_SIGNED_EN
  logic q_neg_r;
  logic r_neg_r;

  assign x_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign y_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign x_mag = dividend;
  assign y_mag = divisor;
`endif

  divider_step #(.WIDTH(WIDTH)) u_step (
    .a      (acc_a),
    .q      (acc_q),
    .m      (m_reg),
    .a_next (a_next),
    .q_next (q_next)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    rem_fix = acc_a[WIDTH] ? (acc_a + {1'b0, m_reg}) : acc_a;
    q_res   = acc_q;
    r_res   = rem_fix[WIDTH-1:0];
`ifdef DIVIDER_SIGNED_EN
    if (q_neg_r) q_res = -acc_q;
    if (r_neg_r) r_res = -rem_fix[WIDTH-1:0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the datapath registers are reset too; a partial result must
      // never be observable after an aborted operation.
      state       <= S_IDLE;
      cnt         <= '0;
      acc_a       <= '0;
      acc_q       <= '0;
      m_reg       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      // Status flags trail the state by one edge.
      busy <= (state == S_RUN) || (state == S_FIX);
      done <= (state == S_DONE);

      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              acc_a <= '0;
              acc_q <= x_mag;
              m_reg <= y_mag;
              cnt   <= CW'(WIDTH);
`ifdef DIVIDER_SIGNED_EN
              q_neg_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_neg_r <= dividend[WIDTH-1];
`endif
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          acc_a <= a_next;
          acc_q <= q_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_FIX;
        end

        S_FIX: begin
          acc_a       <= rem_fix;
          quotient    <= q_res;
          remainder   <= r_res;
          div_by_zero <= 1'b0;
          state       <= S_DONE;
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq_32b.sv
// Self-checking bench for divider_seq_32b: scoreboard of expected results,
// latency/handshake checks and asynchronous reset abort.
module tb_divider_seq_32b;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  divider_seq_32b dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    if (y == 32'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = x;
      e.dbz = 1'b1;
    end else begin
      e.dbz = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        e.q = $signed(x) / $signed(y);
        e.r = $signed(x) % $signed(y);
      end
`else
      e.q = x / y;
      e.r = x % y;
`endif
    end
    return e;
  endfunction

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_q"},   quotient,    e.q);
      check({tag, "_r"},   remainder,   e.r);
      check({tag, "_dbz"}, div_by_zero, e.dbz);
    end
  endtask

  // Drive one operation, count edges from the accepting edge until done.
  // repulse re-asserts start (other operands) at cycles 5 and 20 of the run.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input int exp_lat, input bit repulse);
    int cyc;
    int bcnt;
    @(negedge clk);
    dividend = x;
    divisor  = y;
    start    = 1'b1;
    sb.push_back(model(x, y));
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    cyc  = 0;
    bcnt = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
      if (done) break;
      start = repulse && (cyc == 5 || cyc == 20);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busy_cycles"}, bcnt, exp_lat - 1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    if (done) compare_result(tag);
    else void'(sb.pop_front());
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int gap;
    int ndone;
    int last_done;
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    resetn   = 1'b0;
    #23;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("basic_20_5", 32'd20, 32'd5, 34, 1'b0);
    run_op("big_ffff_10", 32'hFFFF_FFFF, 32'h10, 34, 1'b0);
    run_op("small_7_9", 32'd7, 32'd9, 34, 1'b0);
    run_op("dbz_123_0", 32'd123, 32'd0, 1, 1'b0);
    run_op("after_dbz_10_3", 32'd10, 32'd3, 34, 1'b0);
    run_op("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
    run_op("min_by_m1", 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0);
    run_op("by_one", 32'hDEAD_BEEF, 32'd1, 34, 1'b0);
`ifdef DIVIDER_SIGNED_EN
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 34, 1'b0);
    run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 34, 1'b0);
    run_op("s_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34, 1'b0);
`endif
    for (int i = 0; i < 5; i++) begin
      logic [31:0] rx;
      logic [31:0] ry;
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 30);
      run_op($sformatf("rand%0d", i), rx, ry, 34, 1'b0);
    end

    // Start re-pulsed while busy must be ignored, with no second done.
    run_op("repulse_100_7", 32'd100, 32'd7, 34, 1'b1);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("repulse_no_extra_done", ndone, 0);

    // Start held high: back-to-back operations, one IDLE cycle apart.
    @(negedge clk);
    dividend = 32'd40;
    divisor  = 32'd6;
    start    = 1'b1;
    sb.push_back(model(32'd40, 32'd6));
    sb.push_back(model(32'd40, 32'd6));
    ndone     = 0;
    last_done = 0;
    gap       = 0;
    for (int c = 1; c <= 200 && ndone < 2; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 2) begin
          start = 1'b0;
          gap   = c - last_done;
        end
        last_done = c;
        compare_result($sformatf("held%0d", ndone));
      end
    end
    start = 1'b0;
    check("held_two_dones", ndone, 2);
    check("held_done_spacing", gap, 35);
    while (sb.size() != 0) void'(sb.pop_front());
    repeat (3) @(posedge clk);

    // Asynchronous reset in the middle of a run clears everything at once.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    check("midrun_busy_before", busy, 1'b1);
    resetn = 1'b0;
    #1;
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_done", done, 1'b0);
    check("midrun_rst_q", quotient, 32'd0);
    check("midrun_rst_r", remainder, 32'd0);
    check("midrun_rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    run_op("post_rst_9_4", 32'd9, 32'd4, 34, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
